// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine owning the HI/LO result pair.
// Radix-2 Booth multiply and restoring divide, one step per cycle, start/busy/done handshake.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             sign_a;
    logic             sign_q;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    // Booth: sum is one bit wider so subtracting the most negative multiplicand cannot overflow.
    // Divide: acc holds {0, remainder, quotient/dividend}.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = booth_sum + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = booth_sum - {opnd[WIDTH-1], opnd};
            default: booth_sum = booth_sum;
        endcase
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd};
        abs_a     = a[WIDTH-1] ? -a : a;
        abs_b     = b[WIDTH-1] ? -b : b;
        quot      = acc[WIDTH-1:0];
        rem       = acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_q   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        acc    <= {{WIDTH{1'b0}}, b, 1'b0};
                        opnd   <= a;
                        is_div <= 1'b0;
                        count  <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= MULT;
                    end else if (div_start && b != '0) begin
                        acc    <= {1'b0, {WIDTH{1'b0}}, abs_a};
                        opnd   <= abs_b;
                        is_div <= 1'b1;
                        sign_a <= a[WIDTH-1];
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        count  <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= DIV;
                    end else if (div_start) begin
                        div_zero <= 1'b1;
                    end
                end
                MULT: begin
                    acc   <= {booth_sum, acc[WIDTH:1]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIN;
                end
                DIV: begin
                    if (!rem_diff[WIDTH])
                        acc <= {1'b0, rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else
                        acc <= {1'b0, rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIN;
                end
                FIN: begin
                    if (is_div) begin
                        lo <= sign_q ? -quot : quot;
                        hi <= sign_a ? -rem : rem;
                    end else begin
                        hi <= acc[2*WIDTH:WIDTH+1];
                        lo <= acc[WIDTH:1];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
